// File: rtl/ex_hazard_ctrl_if.sv
// Execute-stage hazard/forwarding bundle.
// Carries the pipeline-side register indices and control bits into the
// hazard controller, and the operand selects, stall/flush strobes, SR freeze
// and performance counters back out.
//   master : pipeline side (drives indices/controls, receives controls)
//   slave  : ex_hazard_ctrl side
interface ex_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 3
);
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned PERF_W = 16;

  logic [REG_AW-1:0] rs1_D;
  logic [REG_AW-1:0] rs2_D;
  logic [REG_AW-1:0] rs1_E;
  logic [REG_AW-1:0] rs2_E;
  logic [REG_AW-1:0] rd_E;
  logic              MemRead_E;
  logic              uses_imm_E;
  logic [REG_AW-1:0] rd_M;
  logic              RegWrite_M;
  logic              MemRead_M;
  logic [REG_AW-1:0] rd_W;
  logic              RegWrite_W;
  logic              Branch_Taken;
  logic              mem_wait;

  logic [SEL_W-1:0]  oper1_sel;
  logic [SEL_W-1:0]  oper2_sel;
  logic [SEL_W-1:0]  Write_Data_sel;
  logic              stall_F;
  logic              stall_D;
  logic              stall_E;
  logic              flush_D;
  logic              flush_E;
  logic              freeze;
  logic [PERF_W-1:0] stall_count;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, MemRead_E, uses_imm_E,
           rd_M, RegWrite_M, MemRead_M, rd_W, RegWrite_W, Branch_Taken, mem_wait,
    input  oper1_sel, oper2_sel, Write_Data_sel, stall_F, stall_D, stall_E,
           flush_D, flush_E, freeze, stall_count, flush_count
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, MemRead_E, uses_imm_E,
           rd_M, RegWrite_M, MemRead_M, rd_W, RegWrite_W, Branch_Taken, mem_wait,
    output oper1_sel, oper2_sel, Write_Data_sel, stall_F, stall_D, stall_E,
           flush_D, flush_E, freeze, stall_count, flush_count
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Hazard/forwarding controller for the execute stage of the 16-bit pipeline.
// Produces the EX operand mux selects (00=register, 01=Write_back,
// 10=ALU_out_MtoE), the F/D/E stall and D/E flush strobes, and the SR freeze.
// A small RUN/STALL/FLUSH sequencer with a down-counter stretches load-use
// stalls and taken-branch flushes over multiple cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ex_hazard_ctrl_if.slave (pipeline indices/controls in, selects,
//          strobes, freeze and perf counters out)
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters;
// without it stall_count/flush_count are tied to zero.
module ex_hazard_ctrl #(
  parameter int unsigned REG_AW            = 3,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned BR_FLUSH_CYCLES   = 1,
  parameter bit          R0_HARDWIRED      = 1'b1
) (
  input logic             clk,
  input logic             rst,
  ex_hazard_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned PERF_W = 16;

  // Counter reload values: the first sequenced cycle happens in RUN, so the
  // remaining cycles spent in STALL/FLUSH are N-1, counted down to zero.
  localparam logic [CNT_W-1:0] LS_RELOAD =
    CNT_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] BR_RELOAD =
    CNT_W'((BR_FLUSH_CYCLES > 1) ? (BR_FLUSH_CYCLES - 2) : 0);

  localparam logic [SEL_W-1:0] SEL_REG = 2'b00;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             e_bubble;

  logic             hazard;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             flush_d;
  logic             flush_e;

  // Forwarding source for one operand index; M beats W, loads in M never forward.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_m,
    input logic              ld_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wr_w
  );
    logic r0_blocked;
    r0_blocked = R0_HARDWIRED && (rs == '0);
    fwd_sel = SEL_REG;
    if (!r0_blocked) begin
      if (wr_m && !ld_m && (rd_m == rs)) begin
        fwd_sel = SEL_MEM;
      end else if (wr_w && (rd_w == rs)) begin
        fwd_sel = SEL_WB;
      end
    end
  endfunction

  // Operand mux selects.
  always_comb begin
    bus.oper1_sel      = fwd_sel(bus.rs1_E, bus.rd_M, bus.RegWrite_M, bus.MemRead_M,
                                 bus.rd_W, bus.RegWrite_W);
    bus.Write_Data_sel = fwd_sel(bus.rs2_E, bus.rd_M, bus.RegWrite_M, bus.MemRead_M,
                                 bus.rd_W, bus.RegWrite_W);
    bus.oper2_sel      = bus.uses_imm_E ? SEL_REG : bus.Write_Data_sel;
  end

  // Load-use hazard between the load in E and the consumer in D.
  always_comb begin
    hazard = bus.MemRead_E
           && !(R0_HARDWIRED && (bus.rd_E == '0))
           && ((bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D));
  end

  // Stall/flush strobes; mem_wait overrides everything and suppresses flushes.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (bus.mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.Branch_Taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        S_STALL: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        S_FLUSH: begin
          flush_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Sequencer and E-bubble tracker; both hold while memory is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      cnt      <= '0;
      e_bubble <= 1'b1;
    end else if (!bus.mem_wait) begin
      e_bubble <= flush_e;
      case (state)
        S_RUN: begin
          if (bus.Branch_Taken) begin
            if (BR_FLUSH_CYCLES > 1) begin
              state <= S_FLUSH;
              cnt   <= BR_RELOAD;
            end
          end else if (hazard) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state <= S_STALL;
              cnt   <= LS_RELOAD;
            end
          end
        end
        S_STALL, S_FLUSH: begin
          if (cnt == '0) begin
            state <= S_RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.stall_F = stall_f;
  assign bus.stall_D = stall_d;
  assign bus.stall_E = stall_e;
  assign bus.flush_D = flush_d;
  assign bus.flush_E = flush_e;
  assign bus.freeze  = bus.mem_wait | e_bubble;

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (flush_e && (flush_cnt_q != {PERF_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`else
  assign bus.stall_count = 16'h0000;
  assign bus.flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: a cycle-level model tracks how many
// forced stall / forced flush_D cycles remain, checked against the DUT every
// negative edge, plus literal expectations for the directed scenarios.
module tb_ex_hazard_ctrl;

  localparam int unsigned AW  = 3;
  localparam int unsigned LS  = 3;
  localparam int unsigned BR  = 2;
  localparam bit          R0  = 1'b1;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  ex_hazard_ctrl_if #(.REG_AW(AW)) bus ();

  ex_hazard_ctrl #(
    .REG_AW           (AW),
    .LOAD_STALL_CYCLES(LS),
    .BR_FLUSH_CYCLES  (BR),
    .R0_HARDWIRED     (R0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_stall_left;   // future cycles of forced load-use stall
  int m_flush_left;   // future cycles of forced flush_D
  bit m_bubble;
  int m_sc, m_fc;
  int n_stall_left, n_flush_left, n_sc, n_fc;
  bit n_bubble;

  task automatic model_reset();
    m_stall_left = 0;
    m_flush_left = 0;
    m_bubble     = 1'b1;
    m_sc         = 0;
    m_fc         = 0;
  endtask

  function automatic logic [1:0] m_sel(input logic [AW-1:0] rs);
    if (R0 && rs == 0) return 2'd0;
    if (bus.RegWrite_M && !bus.MemRead_M && bus.rd_M == rs) return 2'd2;
    if (bus.RegWrite_W && bus.rd_W == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit m_hazard();
    if (!bus.MemRead_E) return 1'b0;
    if (R0 && bus.rd_E == 0) return 1'b0;
    return (bus.rd_E == bus.rs1_D) || (bus.rd_E == bus.rs2_D);
  endfunction

  initial begin
    bit e_sf, e_sd, e_se, e_fd, e_fe;
    logic [1:0] e_o1, e_o2, e_wd;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0;
      if (bus.mem_wait) begin
        e_sf = 1; e_sd = 1; e_se = 1;
      end else if (m_stall_left > 0) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end else if (m_flush_left > 0) begin
        e_fd = 1;
      end else if (bus.Branch_Taken) begin
        e_fd = 1; e_fe = 1;
      end else if (m_hazard()) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
      e_o1 = m_sel(bus.rs1_E);
      e_wd = m_sel(bus.rs2_E);
      e_o2 = bus.uses_imm_E ? 2'd0 : e_wd;

      check("cyc_oper1_sel", 32'(bus.oper1_sel), 32'(e_o1));
      check("cyc_oper2_sel", 32'(bus.oper2_sel), 32'(e_o2));
      check("cyc_wd_sel",    32'(bus.Write_Data_sel), 32'(e_wd));
      check("cyc_stall_F",   32'(bus.stall_F), 32'(e_sf));
      check("cyc_stall_D",   32'(bus.stall_D), 32'(e_sd));
      check("cyc_stall_E",   32'(bus.stall_E), 32'(e_se));
      check("cyc_flush_D",   32'(bus.flush_D), 32'(e_fd));
      check("cyc_flush_E",   32'(bus.flush_E), 32'(e_fe));
      check("cyc_freeze",    32'(bus.freeze), 32'(bus.mem_wait | m_bubble));
`ifdef HAZ_PERF_CNT_EN
      check("cyc_stall_count", 32'(bus.stall_count), 32'(m_sc));
      check("cyc_flush_count", 32'(bus.flush_count), 32'(m_fc));
`else
      check("cyc_stall_count", 32'(bus.stall_count), 32'd0);
      check("cyc_flush_count", 32'(bus.flush_count), 32'd0);
`endif

      n_stall_left = m_stall_left;
      n_flush_left = m_flush_left;
      n_bubble     = m_bubble;
      if (!bus.mem_wait) begin
        n_bubble = e_fe;
        if (m_stall_left > 0)      n_stall_left = m_stall_left - 1;
        else if (m_flush_left > 0) n_flush_left = m_flush_left - 1;
        else if (bus.Branch_Taken) n_flush_left = BR - 1;
        else if (m_hazard())       n_stall_left = LS - 1;
      end
      n_sc = (e_sd && m_sc < 65535) ? m_sc + 1 : m_sc;
      n_fc = (e_fe && m_fc < 65535) ? m_fc + 1 : m_fc;

      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        m_stall_left = n_stall_left;
        m_flush_left = n_flush_left;
        m_bubble     = n_bubble;
        m_sc         = n_sc;
        m_fc         = n_fc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.rs1_D = '0; bus.rs2_D = '0; bus.rs1_E = '0; bus.rs2_E = '0; bus.rd_E = '0;
    bus.MemRead_E = 0; bus.uses_imm_E = 0;
    bus.rd_M = '0; bus.RegWrite_M = 0; bus.MemRead_M = 0;
    bus.rd_W = '0; bus.RegWrite_W = 0;
    bus.Branch_Taken = 0; bus.mem_wait = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls, flushes;
    logic [15:0] sc0;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First cycle after reset: bubble in E freezes SR, nothing else active.
    @(negedge clk);
    check("reset_freeze",  32'(bus.freeze), 32'd1);
    check("reset_flush_D", 32'(bus.flush_D), 32'd0);
    check("reset_stall_F", 32'(bus.stall_F), 32'd0);
    tick();
    @(negedge clk);
    check("reset_freeze_2nd", 32'(bus.freeze), 32'd0);

    // Forwarding priority on operand 1.
    tick(); idle();
    bus.rs1_E = 3'd3; bus.RegWrite_M = 1; bus.rd_M = 3'd3; bus.RegWrite_W = 1; bus.rd_W = 3'd3;
    @(negedge clk);
    check("fwd_m_priority", 32'(bus.oper1_sel), 32'd2);
    tick(); bus.RegWrite_M = 0;
    @(negedge clk);
    check("fwd_w_only", 32'(bus.oper1_sel), 32'd1);
    tick(); bus.RegWrite_M = 1; bus.MemRead_M = 1;
    @(negedge clk);
    check("fwd_load_in_m", 32'(bus.oper1_sel), 32'd1);

    // R0 never forwards; immediate blocks oper2 but not store data.
    tick(); idle();
    bus.rs2_E = 3'd0; bus.rd_M = 3'd0; bus.RegWrite_M = 1;
    @(negedge clk);
    check("r0_oper2", 32'(bus.oper2_sel), 32'd0);
    check("r0_wdata", 32'(bus.Write_Data_sel), 32'd0);
    tick(); bus.uses_imm_E = 1; bus.rd_M = 3'd5; bus.rs2_E = 3'd5;
    @(negedge clk);
    check("imm_oper2",  32'(bus.oper2_sel), 32'd0);
    check("imm_wdata",  32'(bus.Write_Data_sel), 32'd2);
    tick(); idle(); bus.rs2_E = 3'd5; bus.RegWrite_W = 1; bus.rd_W = 3'd5;
    @(negedge clk);
    check("w_oper2", 32'(bus.oper2_sel), 32'd1);

    // Load into r0 is not a hazard.
    tick(); idle(); bus.MemRead_E = 1; bus.rd_E = 3'd0; bus.rs1_D = 3'd0;
    @(negedge clk);
    check("r0_no_hazard", 32'(bus.stall_D), 32'd0);

    // Load-use hazard: exactly LS stall cycles, freeze follows each flush_E.
    tick(); idle(); tick();
    idle(); bus.MemRead_E = 1; bus.rd_E = 3'd2; bus.rs2_D = 3'd2;
    sc0 = bus.stall_count;
    stalls = 0; flushes = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.stall_D) stalls++;
      if (bus.flush_E) flushes++;
      if (c == 0) check("lu_stall_E_low", 32'(bus.stall_E), 32'd0);
      if (c >= 1 && c <= 3) check("lu_freeze_after_flush", 32'(bus.freeze), 32'd1);
      if (c == 4) check("lu_freeze_clear", 32'(bus.freeze), 32'd0);
      tick(); bus.MemRead_E = 0;
    end
    check("lu_stall_cycles", 32'(stalls), 32'd3);
    check("lu_flush_cycles", 32'(flushes), 32'd3);
`ifdef HAZ_PERF_CNT_EN
    check("lu_stall_count", 32'(bus.stall_count - sc0), 32'd3);
`else
    check("lu_stall_count", 32'(bus.stall_count - sc0), 32'd0);
`endif

    // Taken branch: two flush_D cycles, flush_E only on the first.
    idle(); bus.Branch_Taken = 1;
    @(negedge clk);
    check("br_c0_flush_D", 32'(bus.flush_D), 32'd1);
    check("br_c0_flush_E", 32'(bus.flush_E), 32'd1);
    tick(); bus.Branch_Taken = 0;
    @(negedge clk);
    check("br_c1_flush_D", 32'(bus.flush_D), 32'd1);
    check("br_c1_flush_E", 32'(bus.flush_E), 32'd0);
    tick();
    @(negedge clk);
    check("br_c2_flush_D", 32'(bus.flush_D), 32'd0);
    check("br_c2_flush_E", 32'(bus.flush_E), 32'd0);

    // mem_wait in RUN ignores a taken branch.
    tick(); idle(); bus.mem_wait = 1; bus.Branch_Taken = 1;
    @(negedge clk);
    check("mw_run_flush_D", 32'(bus.flush_D), 32'd0);
    check("mw_run_stall_E", 32'(bus.stall_E), 32'd1);
    tick(); idle();
    @(negedge clk);
    check("mw_run_no_flush_after", 32'(bus.flush_D), 32'd0);

    // Hazard with 2 cycles of mem_wait inside STALL: stall stretches by 2.
    tick(); idle(); tick();
    idle(); bus.MemRead_E = 1; bus.rd_E = 3'd2; bus.rs1_D = 3'd2;
    stalls = 0; flushes = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (bus.stall_D) stalls++;
      if (bus.flush_E) flushes++;
      if (c == 1 || c == 2) begin
        check("mw_stall_E", 32'(bus.stall_E), 32'd1);
        check("mw_no_flush_E", 32'(bus.flush_E), 32'd0);
      end
      if (c == 3) check("mw_bubble_held", 32'(bus.freeze), 32'd1);
      tick(); bus.MemRead_E = 0; bus.mem_wait = (c == 0 || c == 1);
    end
    check("mw_stall_cycles", 32'(stalls), 32'd5);
    check("mw_flush_cycles", 32'(flushes), 32'd3);

    // Async reset in the middle of a branch flush.
    idle(); bus.Branch_Taken = 1;
    @(negedge clk);
    check("rst_br_flush_D", 32'(bus.flush_D), 32'd1);
    tick(); bus.Branch_Taken = 0;
    check("rst_pre_flush_D", 32'(bus.flush_D), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_flush_D", 32'(bus.flush_D), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_release_freeze", 32'(bus.freeze), 32'd1);
    check("rst_release_flush_D", 32'(bus.flush_D), 32'd0);
    tick();
    @(negedge clk);
    check("rst_release_freeze_2nd", 32'(bus.freeze), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
